// File: rtl/vip_bayer2rgb_3x3.sv
// Bilinear 3x3 Bayer demosaic: classifies each window centre as R/Gr/Gb/B from
// internal row/column parity and emits one RGB pixel per window, 2 clk later.
module vip_bayer2rgb_3x3 #(
   parameter logic [1:0] BAYER_PATTERN = 2'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       matrix_frame_vsync,
   input  logic       matrix_frame_href,
   input  logic       matrix_frame_clken,
   input  logic [7:0] matrix_p11,
   input  logic [7:0] matrix_p12,
   input  logic [7:0] matrix_p13,
   input  logic [7:0] matrix_p21,
   input  logic [7:0] matrix_p22,
   input  logic [7:0] matrix_p23,
   input  logic [7:0] matrix_p31,
   input  logic [7:0] matrix_p32,
   input  logic [7:0] matrix_p33,
   output logic       post_frame_vsync,
   output logic       post_frame_href,
   output logic       post_frame_clken,
   output logic [7:0] post_img_red,
   output logic [7:0] post_img_green,
   output logic [7:0] post_img_blue
);

   typedef enum logic [1:0] {
      SITE_R  = 2'b00,
      SITE_GR = 2'b01,
      SITE_GB = 2'b10,
      SITE_B  = 2'b11
   } site_e;

   // Sync delay line, bit order {vsync, href, clken}; stage 1 doubles as the edge-detect history.
   logic [2:0] sync1_q, sync1_d;
   logic [2:0] sync2_q, sync2_d;
   logic       col_odd_q, col_odd_d;
   logic       row_odd_q, row_odd_d;
   logic [9:0] cross_q, cross_d;
   logic [9:0] diag_q, diag_d;
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic [7:0] p22_q, p22_d;
   site_e      site_q, site_d;
   logic [7:0] red_q, red_d;
   logic [7:0] green_q, green_d;
   logic [7:0] blue_q, blue_d;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path can infer a latch.
      sync1_d   = {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken};
      sync2_d   = sync1_q;
      col_odd_d = col_odd_q;
      row_odd_d = row_odd_q;
      cross_d   = cross_q;
      diag_d    = diag_q;
      h_d       = h_q;
      v_d       = v_q;
      p22_d     = p22_q;
      site_d    = site_q;
      red_d     = red_q;
      green_d   = green_q;
      blue_d    = blue_q;

      if (!matrix_frame_href)
         col_odd_d = 1'b0;
      else if (matrix_frame_clken)
         col_odd_d = ~col_odd_q;

      // Frame start outranks the line-end toggle when both land on one cycle.
      if (matrix_frame_vsync && !sync1_q[2])
         row_odd_d = 1'b0;
      else if (sync1_q[1] && !matrix_frame_href)
         row_odd_d = ~row_odd_q;

      if (matrix_frame_clken) begin
         cross_d = {2'b00, matrix_p12} + {2'b00, matrix_p21}
                 + {2'b00, matrix_p23} + {2'b00, matrix_p32};
         diag_d  = {2'b00, matrix_p11} + {2'b00, matrix_p13}
                 + {2'b00, matrix_p31} + {2'b00, matrix_p33};
         h_d     = {2'b00, matrix_p21} + {2'b00, matrix_p23};
         v_d     = {2'b00, matrix_p12} + {2'b00, matrix_p32};
         p22_d   = matrix_p22;
         site_d  = site_e'({row_odd_q ^ BAYER_PATTERN[1], col_odd_q ^ BAYER_PATTERN[0]});
      end

      if (sync1_q[0]) begin
         case (site_q)
            SITE_R: begin
               red_d   = p22_q;
               green_d = cross_q[9:2];
               blue_d  = diag_q[9:2];
            end
            SITE_B: begin
               red_d   = diag_q[9:2];
               green_d = cross_q[9:2];
               blue_d  = p22_q;
            end
            SITE_GR: begin
               red_d   = h_q[8:1];
               green_d = p22_q;
               blue_d  = v_q[8:1];
            end
            SITE_GB: begin
               red_d   = v_q[8:1];
               green_d = p22_q;
               blue_d  = h_q[8:1];
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignment so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         col_odd_q <= 1'b0;
         row_odd_q <= 1'b0;
         cross_q   <= '0;
         diag_q    <= '0;
         h_q       <= '0;
         v_q       <= '0;
         p22_q     <= '0;
         site_q    <= SITE_R;
         red_q     <= '0;
         green_q   <= '0;
         blue_q    <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         col_odd_q <= col_odd_d;
         row_odd_q <= row_odd_d;
         cross_q   <= cross_d;
         diag_q    <= diag_d;
         h_q       <= h_d;
         v_q       <= v_d;
         p22_q     <= p22_d;
         site_q    <= site_d;
         red_q     <= red_d;
         green_q   <= green_d;
         blue_q    <= blue_d;
      end
   end

   assign post_frame_vsync = sync2_q[2];
   assign post_frame_href  = sync2_q[1];
   assign post_frame_clken = sync2_q[0];
   assign post_img_red     = red_q;
   assign post_img_green   = green_q;
   assign post_img_blue    = blue_q;

endmodule

// File: doc/vip_bayer2rgb_3x3.md
Name: vip_bayer2rgb_3x3

Overview:
- Demosaic stage directly downstream of vip_matrix_generate_3x3_8bit.
- Consumes its 3x3 raw-Bayer window (matrix_p11..p33) and frame syncs, and produces one 24-bit RGB pixel per valid window by bilinear interpolation.
- Tracks row/column parity internally to classify each centre pixel as R, Gr, Gb or B.
- Feeds the RGB post-processing / display path.

Parameters:
- BAYER_PATTERN, 2'd0: CFA phase of pixel (row0,col0). 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.

Ports:
- clk  input  1  pixel clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- matrix_frame_vsync  input  1  frame sync from matrix generator.
- matrix_frame_href  input  1  line valid from matrix generator.
- matrix_frame_clken  input  1  window valid strobe; one pixel per high cycle.
- matrix_p11..matrix_p33  input  8 each (9 ports)  3x3 window; p22 = centre, p1x = row above, p3x = row below.
- post_frame_vsync  output  1  vsync delayed 2 clk.
- post_frame_href  output  1  href delayed 2 clk.
- post_frame_clken  output  1  clken delayed 2 clk.
- post_img_red  output  8  interpolated R.
- post_img_green  output  8  interpolated G.
- post_img_blue  output  8  interpolated B.

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0; parity counters 0; pipeline registers 0. Reset mid-line discards in-flight pixels; the first window after reset is treated as row 0, col 0.
- Column parity col_odd:
  - Cleared when href=0.
  - Toggles after each cycle with clken=1 and href=1.
  - The value used for a window is the value before the toggle.
- Row parity row_odd:
  - Cleared on the vsync rising edge (registered vsync_d=0, vsync=1).
  - Toggles on each href falling edge (href_d=1, href=0).
  - When a vsync rise and an href fall coincide, the clear wins.
- Site decode:
  - r = row_odd ^ BAYER_PATTERN[1]; c = col_odd ^ BAYER_PATTERN[0].
  - (0,0)=R, (0,1)=Gr (G on R row), (1,0)=Gb (G on B row), (1,1)=B.
- Stage 1 (registered when clken=1; holds otherwise):
  - 10-bit sums: cross = p12+p21+p23+p32; diag = p11+p13+p31+p33; h = p21+p23; v = p12+p32.
  - Also register p22 and the 2-bit site code.
- Stage 2 (registered when stage-1 valid; holds otherwise). Division is a truncating right shift (cross>>2, diag>>2, h>>1, v>>1):
  - R site: R=p22, G=cross>>2, B=diag>>2.
  - B site: R=diag>>2, G=cross>>2, B=p22.
  - Gr site: R=h>>1, G=p22, B=v>>1.
  - Gb site: R=v>>1, G=p22, B=h>>1.
- Latency: exactly 2 clk from matrix_* inputs to post_* outputs, for both data and syncs.
  - Sync signals go through a plain 2-deep shift register, regardless of clken.
  - Output data is valid only when post_frame_clken=1; RGB holds its last value otherwise.
- No overflow: max sum 4*255=1020 fits in 10 bits; results are always <= 255.
- No back-pressure: the block accepts one window per clk continuously (throughput 1 pixel/clk).
- Frame edges: the block interpolates whatever window it is given and adds no border handling of its own. Border replication is the upstream generator's job.

Test Plan:
1. Reset/latency: rst=1 for 2 clk, then one window with clken=1 at cycle N -> post_frame_clken=1 at exactly N+2; all outputs 0 during reset.
2. R site, BAYER_PATTERN=0, first pixel of a frame, p22=200, p12=p21=p23=p32=100, p11=p13=p31=p33=40 -> RGB = (200,100,40).
3. Gr/Gb alternation, pattern 0: one line of 4 windows, each with p21=p23=10, p12=p32=30, p22=77 -> col1 RGB=(10,77,30). After an href low gap, the second line's col0 is a Gb site with RGB=(30,77,10).
4. Truncation, B site (row1, col1): cross values 1,1,1,2 (sum 5) -> G=1; diag=255 x4 -> R=255.
5. Pattern parameter: BAYER_PATTERN=3, row0 col0 window from test 2 -> treated as B: RGB = (40,100,200).
6. clken gaps and reset mid-line:
   - clken toggles 1,0,1 within href -> column parity advances only on clken=1, and RGB holds during the gap.
   - Assert rst mid-line -> the next window decodes as row0/col0.
